// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer: PC/MAR/MDR/IR datapath with memory handshake,
// redirect, consumer backpressure and a sticky memory-timeout fault.
module fetch_unit #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              fault
);

    localparam int            TW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_LATCH,
        S_ISSUE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] mdr_q;
    logic [DATA_W-1:0] ir_q;
    logic [ADDR_W-1:0] ir_pc_q;
    logic              ir_valid_q;
    logic              fault_q;
    logic [TW-1:0]     timer_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            mar_q      <= '0;
            mdr_q      <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            timer_q    <= '0;
        end else if (redirect) begin
            // Redirect outranks everything; any data returned this cycle is dropped.
            pc_q       <= redirect_pc;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            timer_q    <= '0;
            state_q    <= run ? S_ADDR : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run && !fault_q) begin
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    mar_q   <= pc_q;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        mdr_q   <= mem_rdata;
                        timer_q <= '0;
                        state_q <= S_LATCH;
                    end else if ((TIMEOUT != 0) && (timer_q == T_LAST)) begin
                        fault_q <= 1'b1;
                        timer_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_LATCH: begin
                    ir_q       <= mdr_q;
                    ir_pc_q    <= mar_q;
                    pc_q       <= pc_q + ADDR_W'(1);
                    ir_valid_q <= 1'b1;
                    state_q    <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (ir_ack) begin
                        ir_valid_q <= 1'b0;
                        state_q    <= run ? S_ADDR : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Decoded from the registered state so an async reset drops the request at once.
    assign mem_req  = (state_q == S_WAIT);
    assign mem_addr = mar_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign pc       = pc_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit with an expected-fetch scoreboard.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        run;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ack;
    logic [15:0] pc;
    logic        fault;

    logic        use_fixed;
    logic [15:0] fixed_data;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    int tests;
    int fails;

    fetch_unit #(
        .DATA_W  (16),
        .ADDR_W  (16),
        .RESET_PC(16'h0000),
        .TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .mem_addr   (mem_addr),
        .mem_req    (mem_req),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .ir_ack     (ir_ack),
        .pc         (pc),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: a fixed word on demand, otherwise a pattern keyed by address.
    assign mem_rdata = use_fixed ? fixed_data : (mem_addr ^ 16'hA5A5);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pat(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    task automatic push(input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic expect_issue(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!ir_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, ir_valid, 1);
        chk({tag, "_sb"}, (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_ir"}, ir, e.data);
            chk({tag, "_ir_pc"}, ir_pc, e.addr);
        end
    endtask

    initial begin
        int cnt;
        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        run         = 1'b0;
        mem_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        ir_ack      = 1'b0;
        use_fixed   = 1'b1;
        fixed_data  = 16'h1234;

        #2;
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_fault", fault, 0);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_ir_pc", ir_pc, 16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);

        // Basic fetch: four edges from run to ir_valid.
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        run       = 1'b1;
        mem_ready = 1'b1;
        push(16'h0000, 16'h1234);
        tick();
        tick();
        tick();
        chk("lat_not_yet", ir_valid, 0);
        tick();
        chk("lat_4_edges", ir_valid, 1);
        expect_issue("basic");
        chk("basic_pc", pc, 16'h0001);

        // Backpressure: ir held, no memory traffic.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_ir", ir, 16'h1234);
            chk("bp_ir_pc", ir_pc, 16'h0000);
            chk("bp_valid", ir_valid, 1);
            chk("bp_mem_req", mem_req, 0);
        end

        // Steady state: one instruction every 4 cycles.
        use_fixed = 1'b0;
        ir_ack    = 1'b1;
        tick();
        for (int k = 1; k <= 3; k++) begin
            push(16'(k), pat(16'(k)));
            tick();
            tick();
            chk("ss_gap", ir_valid, 0);
            tick();
            chk("ss_issue", ir_valid, 1);
            expect_issue("steady");
            tick();
            chk("ss_consumed", ir_valid, 0);
        end
        chk("ss_pc", pc, 16'h0004);

        // Wait states: three not-ready WAIT cycles, then data.
        ir_ack     = 1'b0;
        mem_ready  = 1'b0;
        use_fixed  = 1'b1;
        fixed_data = 16'hABCD;
        push(16'h0004, 16'hABCD);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ir_valid) break;
            if (mem_req) begin
                cnt++;
                if (cnt == 4) mem_ready = 1'b1;
            end
        end
        chk("ws_req_cycles", cnt, 4);
        expect_issue("wait");
        chk("ws_fault", fault, 0);
        use_fixed = 1'b0;

        // Redirect coinciding with ir_ack in ISSUE.
        ir_ack      = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0500;
        push(16'h0500, pat(16'h0500));
        tick();
        redirect = 1'b0;
        ir_ack   = 1'b0;
        chk("ra_valid_clr", ir_valid, 0);
        chk("ra_pc", pc, 16'h0500);
        expect_issue("redir_ack");

        // Redirect coinciding with mem_ready: returned word discarded.
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        tick();
        chk("race_in_wait", mem_req, 1);
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        use_fixed   = 1'b1;
        fixed_data  = 16'hDEAD;
        push(16'h0200, pat(16'h0200));
        tick();
        redirect  = 1'b0;
        use_fixed = 1'b0;
        chk("race_pc", pc, 16'h0200);
        chk("race_req", mem_req, 0);
        chk("race_valid", ir_valid, 0);
        expect_issue("race");

        // PC wrap, with run dropped mid-fetch.
        ir_ack      = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        push(16'hFFFF, pat(16'hFFFF));
        tick();
        redirect = 1'b0;
        ir_ack   = 1'b0;
        run      = 1'b0;
        expect_issue("wrap");
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_fault", fault, 0);
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        chk("stop_valid", ir_valid, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stop_idle_req", mem_req, 0);
        end
        chk("stop_pc", pc, 16'h0000);

        // Timeout: 15 WAIT cycles without ready, then sticky fault in IDLE.
        run       = 1'b1;
        mem_ready = 1'b0;
        cnt       = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mem_req) cnt++;
            if (fault) break;
        end
        chk("to_fault", fault, 1);
        chk("to_wait_cycles", cnt, 15);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("to_idle_req", mem_req, 0);
            chk("to_sticky", fault, 1);
        end
        redirect    = 1'b1;
        redirect_pc = 16'h3000;
        tick();
        redirect = 1'b0;
        chk("to_clear", fault, 0);
        tick();
        chk("to_req", mem_req, 1);
        chk("to_addr", mem_addr, 16'h3000);

        // Async reset between edges while in WAIT.
        #2;
        reset = 1'b1;
        #1;
        chk("ar_req", mem_req, 0);
        chk("ar_pc", pc, 16'h0000);
        chk("ar_valid", ir_valid, 0);
        chk("ar_fault", fault, 0);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, the instruction/MDR/IR width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 16, the PC/MAR/memory address width in bits.
REQ-003 The module SHALL have parameter RESET_PC, default 0, the PC value loaded on reset.
REQ-004 The module SHALL have parameter TIMEOUT, default 15, the maximum WAIT cycles without mem_ready; 0 disables the timeout.
REQ-005 The module SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-006 The module SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-007 The module SHALL have port run, input, 1, which enables fetching.
REQ-008 The module SHALL have port mem_addr, output, ADDR_W, the memory address driven from MAR.
REQ-009 The module SHALL have port mem_req, output, 1, the memory read request.
REQ-010 The module SHALL have port mem_rdata, input, DATA_W, the memory read data.
REQ-011 The module SHALL have port mem_ready, input, 1, indicating mem_rdata is valid this cycle.
REQ-012 The module SHALL have port redirect, input, 1, a PC load request (branch/JSR/JMP).
REQ-013 The module SHALL have port redirect_pc, input, ADDR_W, the target PC.
REQ-014 The module SHALL have port ir, output, DATA_W, the fetched instruction.
REQ-015 The module SHALL have port ir_pc, output, ADDR_W, the address from which ir was fetched.
REQ-016 The module SHALL have port ir_valid, output, 1, asserted while ir is offered.
REQ-017 The module SHALL have port ir_ack, input, 1, driven by the consumer to accept ir.
REQ-018 The module SHALL have port pc, output, ADDR_W, the current PC.
REQ-019 The module SHALL have port fault, output, 1, a sticky memory-timeout flag.

Function
REQ-020 The FSM SHALL have the states IDLE, ADDR, WAIT, LATCH and ISSUE.
REQ-021 In IDLE, with run=1 and fault=0, the FSM SHALL go to ADDR; otherwise it SHALL stay in IDLE.
REQ-022 In ADDR, the FSM SHALL load MAR with PC and go to WAIT.
REQ-023 mem_req SHALL be 1 exactly while the state is WAIT, decoded from the registered state, and mem_addr SHALL equal MAR.
REQ-024 In WAIT, when mem_ready=1, the FSM SHALL load MDR with mem_rdata, clear the timer, and go to LATCH.
REQ-025 In WAIT, when mem_ready=0, the timer SHALL increment.
REQ-026 When TIMEOUT is nonzero and the timer reaches TIMEOUT, the FSM SHALL set fault, clear the timer and go to IDLE.
REQ-027 In LATCH, the FSM SHALL load IR with MDR, load ir_pc with MAR, set PC to PC+1 modulo 2^ADDR_W, set ir_valid, and go to ISSUE.
REQ-028 In ISSUE, ir_valid SHALL be held and ir/ir_pc SHALL be held stable until ir_ack=1.
REQ-029 On ir_ack=1 in ISSUE, the FSM SHALL clear ir_valid and go to ADDR if run=1, otherwise to IDLE.
REQ-030 ir_ack SHALL be ignored outside ISSUE.
REQ-031 redirect=1 at any edge and in any state SHALL load PC with redirect_pc, clear ir_valid, fault and the timer, and move the FSM to ADDR if run=1, otherwise to IDLE.
REQ-032 A redirect SHALL take priority over a simultaneous mem_ready, timeout, or ir_ack, and data returned in that cycle SHALL be discarded.
REQ-033 Deasserting run SHALL NOT abort an in-flight fetch; the fetch SHALL complete through ISSUE, and the FSM SHALL then enter IDLE.
REQ-034 Latency from run rising in IDLE, with mem_ready tied to 1, to ir_valid high SHALL be 4 clock edges.
REQ-035 In steady state, with ir_ack and mem_ready tied to 1, the unit SHALL issue one instruction every 4 cycles.
REQ-036 PC wrap SHALL follow the modulo rule: PC = 2^ADDR_W-1 fetches that address, then PC becomes 0, with no flag.

Reset
REQ-037 While reset=1, asynchronously: state=IDLE, PC=RESET_PC, MAR=0, MDR=0, IR=0, ir_pc=0, ir_valid=0, mem_req=0, fault=0, timer=0.
REQ-038 Reset asserted mid-fetch SHALL abandon the fetch immediately, with mem_req low in the same cycle.
REQ-039 After reset deasserts with run=1, fetching SHALL begin at the first edge.

Verification
REQ-040 Basic fetch: reset, run=1, mem_ready=1, mem_rdata=16'h1234 -> after 4 edges: ir_valid=1, ir=16'h1234, ir_pc=0, pc=1.
REQ-041 Wait states: mem_ready held low for 3 WAIT cycles, then high with data 16'hABCD -> mem_req high for 4 cycles, ir=16'hABCD, fault=0.
REQ-042 Timeout: TIMEOUT=15, mem_ready never high -> fault=1 after 15 WAIT cycles, FSM returns to IDLE and stays idle with run=1; redirect with redirect_pc=16'h3000 -> fault=0, next mem_addr=16'h3000.
REQ-043 Redirect races: redirect with redirect_pc=16'h0200 in the same cycle as mem_ready -> data discarded, next ir_pc=16'h0200; redirect with ir_ack in ISSUE -> next ir_pc=redirect_pc.
REQ-044 Backpressure and wrap: ir_ack held low for 10 cycles -> ir stable, mem_req stays low; PC=16'hFFFF -> ir_pc=16'hFFFF, then pc=0.
REQ-045 Async reset: assert reset during WAIT, between clock edges -> mem_req=0 and pc=RESET_PC immediately, with no clock edge required.
